// File: rtl/dp_pkg.sv
// Shared types and constants for the result accumulator slice.
package dp_pkg;

   localparam int unsigned DP_N     = 16;
   localparam int unsigned DP_PIPE  = 1;
   localparam int unsigned DP_ACC_W = 32;
   localparam int unsigned DP_LEN_W = 8;

   typedef enum logic [0:0] {
      IDLE,
      ACCUM
   } dp_state_e;

   // Completed vector result at the default widths.
   typedef struct packed {
      logic signed [DP_ACC_W-1:0] sum;
      logic                       ovf;
      logic [DP_LEN_W-1:0]        count;
      logic [DP_LEN_W-1:0]        carries;
   } dp_entry_t;

   // Largest positive value of a w-bit two's-complement number.
   function automatic logic signed [63:0] sat_max(input int unsigned w);
      sat_max = (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Most negative value of a w-bit two's-complement number.
   function automatic logic signed [63:0] sat_min(input int unsigned w);
      sat_min = -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/dp_result_fifo2.sv
// Two-entry FIFO of completed vector results; the head is always visible.
module dp_result_fifo2
   import dp_pkg::*;
#(
   parameter type entry_t = dp_entry_t
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  entry_t     push_data,
   input  logic       pop,
   output entry_t     head,
   output logic [1:0] count,
   output logic       full,
   output logic       empty
);

   entry_t     mem_q [2];
   logic       wr_q;
   logic       rd_q;
   logic [1:0] count_q;
   logic       do_push;
   logic       do_pop;

   assign empty   = (count_q == 2'd0);
   assign full    = (count_q == 2'd2);
   assign count   = count_q;
   assign head    = mem_q[rd_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & ~full;

   // Storage, pointers and occupancy; push and pop may share an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= ~wr_q;
         end
         if (do_pop) begin
            rd_q <= ~rd_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/dp_result_accumulator.sv
// Reduces a vector of datapath results into one saturated signed sum, with
// issue-strobe realignment, a 2-entry output buffer and credit back-pressure.
module dp_result_accumulator
   import dp_pkg::*;
#(
   parameter int unsigned N     = DP_N,
   parameter int unsigned PIPE  = DP_PIPE,
   parameter int unsigned ACC_W = DP_ACC_W,
   parameter int unsigned LEN_W = DP_LEN_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic                    in_ready,
   input  logic signed [N-1:0]     Y,
   input  logic                    co,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_sum,
   output logic                    out_ovf,
   output logic [LEN_W-1:0]        out_count,
   output logic [LEN_W-1:0]        out_carries
);

   typedef struct packed {
      logic signed [ACC_W-1:0] sum;
      logic                    ovf;
      logic [LEN_W-1:0]        count;
      logic [LEN_W-1:0]        carries;
   } entry_t;

   localparam logic signed [ACC_W-1:0] AccMax = ACC_W'(sat_max(ACC_W));
   localparam logic signed [ACC_W-1:0] AccMin = ACC_W'(sat_min(ACC_W));

   logic                    accept;
   logic                    d_valid;
   logic                    d_last;
   logic [2:0]              inflight;
   dp_state_e               state_q;
   entry_t                  cur_q;
   entry_t                  nxt;
   entry_t                  head;
   logic signed [ACC_W-1:0] y_ext;
   logic signed [ACC_W:0]   wide_sum;
   logic                    sat;
   logic                    push;
   logic                    pop;
   logic [1:0]              buf_count;
   logic                    buf_full;
   logic                    buf_empty;

   // Strobes issued without credit are dropped here, before the delay line.
   assign accept = in_valid & in_ready;

   if (PIPE == 0) begin : g_nopipe
      assign d_valid  = accept;
      assign d_last   = accept & in_last;
      assign inflight = 3'd0;
   end else begin : g_pipe
      logic [PIPE-1:0] v_q;
      logic [PIPE-1:0] l_q;

      // Delay issue strobes to line up with the datapath result.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= '0;
            l_q <= '0;
         end else begin
            v_q[0] <= accept;
            l_q[0] <= accept & in_last;
            for (int unsigned i = 1; i < PIPE; i++) begin
               v_q[i] <= v_q[i-1];
               l_q[i] <= l_q[i-1];
            end
         end
      end

      assign d_valid = v_q[PIPE-1];
      assign d_last  = l_q[PIPE-1];

      // Last markers still travelling each hold a future buffer slot.
      always_comb begin
         inflight = 3'd0;
         for (int unsigned i = 0; i < PIPE; i++) begin
            inflight = inflight + {2'b00, l_q[i]};
         end
      end
   end

   assign in_ready = (({1'b0, buf_count} + inflight) < 3'd2);

   assign y_ext    = {{(ACC_W-N){Y[N-1]}}, Y};
   assign wide_sum = {cur_q.sum[ACC_W-1], cur_q.sum} + {y_ext[ACC_W-1], y_ext};
   assign sat      = (wide_sum[ACC_W] != wide_sum[ACC_W-1]);

   // Post-update accumulator; this is also what gets pushed on a last element.
   always_comb begin
      nxt.sum     = y_ext;
      nxt.ovf     = 1'b0;
      nxt.count   = LEN_W'(1);
      nxt.carries = {{(LEN_W-1){1'b0}}, co};
      if (state_q == ACCUM) begin
         if (sat) begin
            nxt.sum = wide_sum[ACC_W] ? AccMin : AccMax;
         end else begin
            nxt.sum = wide_sum[ACC_W-1:0];
         end
         nxt.ovf     = cur_q.ovf | sat;
         nxt.count   = (&cur_q.count) ? cur_q.count : cur_q.count + 1'b1;
         nxt.carries = (co && !(&cur_q.carries)) ? cur_q.carries + 1'b1 : cur_q.carries;
      end
   end

   // FSM and accumulator registers advance once per aligned element.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cur_q   <= '0;
      end else if (d_valid) begin
         cur_q   <= nxt;
         state_q <= d_last ? IDLE : ACCUM;
      end
   end

   assign push = d_valid & d_last;
   assign pop  = out_valid & out_ready;

   dp_result_fifo2 #(
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (nxt),
      .pop       (pop),
      .head      (head),
      .count     (buf_count),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   assign out_valid   = ~buf_empty;
   assign out_sum     = head.sum;
   assign out_ovf     = head.ovf;
   assign out_count   = head.count;
   assign out_carries = head.carries;

endmodule

// File: doc/dp_result_accumulator.md
# dp_result_accumulator

Downstream stage of the arithmetic datapath: consumes the datapath's per-cycle result `Y`/`co` and reduces a vector of results into one saturated signed sum per neuron. A delay line of depth `PIPE` realigns the issue-side `in_valid`/`in_last` strobes with the datapath's pipelined output. Completed sums go through a 2-entry output buffer with a valid/ready handshake. `in_ready` back-pressures the operand issuer so no completed sum is ever dropped.

## Interface
- `N`, 16, datapath result width; must match the upstream datapath.
- `PIPE`, 1, datapath latency in cycles (0..4); must match the upstream `pipe` setting.
- `ACC_W`, 32, accumulator and output sum width (≥ N+1).
- `LEN_W`, 8, width of the element and carry counters.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands were issued to the datapath this cycle.
- `in_last`  in  1  issued operands are the last element of the vector; qualified by `in_valid`.
- `in_ready`  out  1  issuer may assert `in_valid` this cycle.
- `Y`  in  N  signed datapath result.
- `co`  in  1  datapath carry-out.
- `out_valid`  out  1  head of the output buffer holds a completed sum.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_sum`  out  ACC_W  signed, saturated vector sum.
- `out_ovf`  out  1  saturation occurred at least once in this vector.
- `out_count`  out  LEN_W  number of elements in the vector (saturating).
- `out_carries`  out  LEN_W  number of elements with `co`=1 (saturating).

## Operation
- Delay line: `PIPE` register stages carry {valid, last}. At the tap, `d_valid`/`d_last` are aligned with `Y`/`co`. With `PIPE`=0 the tap is combinational.
- FSM, per accepted element, where accepted means `d_valid`=1:
  - IDLE: no partial vector. Load `acc=sext(Y)`, `cnt=1`, `carr=co`, `ovf=0`.
    - Next state is ACCUM if `d_last`=0.
    - If `d_last`=1, push to the buffer and stay in IDLE.
  - ACCUM: compute `acc+sext(Y)` in ACC_W+1 bits.
    - On signed overflow, clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set `ovf`.
    - Increment `cnt` and `carr`; both saturate at 2^LEN_W-1.
    - When `d_last`=1, push {acc, ovf, cnt, carr} and return to IDLE.
- A push and the accumulation happen on the same edge. The pushed entry carries the post-update values.
- Output buffer: 2-entry FIFO. The head drives the `out_*` ports.
  - Pop when `out_valid & out_ready`.
  - Push and pop on the same edge are both performed; occupancy is unchanged.
- Credit rule: `in_ready = (occupancy + in-flight last markers in the delay line) < 2`. This is combinational from registers only.
  - A push into a full buffer cannot occur. A bench assertion flags any such attempt.
- `in_valid` while `in_ready`=0 is a protocol violation. The strobe is ignored and does not enter the delay line.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0.
  - `out_sum`, `out_ovf`, `out_count`, `out_carries` all 0.
  - FSM in IDLE; delay line and buffer cleared.
- Element issued at cycle t is accumulated on the edge ending cycle t+`PIPE`.
- For a last element issued at t, `out_valid` rises in cycle t+`PIPE`+1 if the buffer was empty.
- Throughput: one element per cycle. Back-to-back vectors need no bubble.
- An `out_valid` head is held stable until popped.
- Reset asserted mid-vector or mid-flight:
  - The partial sum, in-flight strobes and buffered results are discarded immediately.
  - Outputs return to their reset values asynchronously.

## Structure
- `dp_pkg` holds:
  - the FSM state enum {IDLE, ACCUM};
  - a packed result-entry struct {sum, ovf, count, carries};
  - the default width constants and `SAT_MAX`/`SAT_MIN` helper functions.
- Sub-module `dp_result_fifo2`: 2-deep FIFO of result entries with push/pop, `count[1:0]`, `full` and `empty`.
- Top level holds the delay line, FSM, accumulator and credit logic.

## Test plan
- `PIPE`=1, vector Y = 5, -3, 10 (last on 10) -> `out_sum`=12, `out_count`=3, `out_ovf`=0, `out_valid` rises 2 cycles after the last issue.
- Single-element vector Y=-7 with `co`=1 -> `out_sum`=-7, `out_count`=1, `out_carries`=1. FSM never leaves IDLE.
- `ACC_W`=17, `N`=16, four elements of Y=32767 -> `out_sum`=65535 (saturated), `out_ovf`=1.
- Hold `out_ready`=0 and issue three one-element vectors -> after two vectors are in flight or buffered, `in_ready` drops to 0. Raising `out_ready` for one cycle -> `in_ready` returns to 1 the next cycle; no result is lost or duplicated.
- Buffer holding 1 entry, pop and push on the same edge -> occupancy stays 1, and the new entry appears at the head next cycle.
- Assert `rst_n`=0 mid-vector after Y=4, 4, then issue Y=1 (last) -> `out_sum`=1, `out_count`=1.
